// File: rtl/cache_axi_rd_arb.sv
// rtl/cache_axi_rd_arb.sv - round-robin read arbiter from cache refill ports onto one AXI3 AR/R pair
module cache_axi_rd_arb #(
  parameter int NUM_PORTS  = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [NUM_PORTS-1:0]      rd_req,
  input  logic [3*NUM_PORTS-1:0]    rd_type,
  input  logic [32*NUM_PORTS-1:0]   rd_addr,
  output logic [NUM_PORTS-1:0]      rd_rdy,
  output logic [NUM_PORTS-1:0]      ret_valid,
  output logic [NUM_PORTS-1:0]      ret_last,
  output logic [31:0]               ret_data,
  output logic [3:0]                arid,
  output logic [31:0]               araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic [1:0]                arlock,
  output logic [3:0]                arcache,
  output logic [2:0]                arprot,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [3:0]                rid,
  input  logic [31:0]               rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready,
  output logic                      err_resp,
  output logic                      err_id
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0] busy;
  logic [NUM_PORTS-1:0] eligible;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        grant_idx;
  logic [PW-1:0]        next_ptr;
  logic [PW-1:0]        scan_idx;
  logic [PW:0]          scan_sum;
  logic                 grant_vld;
  logic [2:0]           g_type;
  logic [31:0]          g_addr;
  logic                 g_line;
  logic [1:0]           g_size;
  logic                 rid_ok;

  assign eligible = rd_req & ~busy;

  // Scan ports from rr_ptr upward (wrapping) for the first eligible one; no grant while an AR is pending
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    rd_rdy    = '0;
    if (!arvalid) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        scan_sum = {1'b0, rr_ptr} + (PW+1)'(k);
        if (scan_sum >= (PW+1)'(NUM_PORTS)) begin
          scan_sum = scan_sum - (PW+1)'(NUM_PORTS);
        end
        scan_idx = scan_sum[PW-1:0];
        if (!grant_vld && eligible[scan_idx]) begin
          grant_vld = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
    if (grant_vld) begin
      rd_rdy[grant_idx] = 1'b1;
    end
  end

  assign g_type   = rd_type[3*grant_idx +: 3];
  assign g_addr   = rd_addr[32*grant_idx +: 32];
  assign g_line   = (g_type == 3'b100);
  // Byte/half/word keep their encoded size; line reads and unknown types become word-sized
  assign g_size   = (!g_type[2] && (g_type[1:0] != 2'b11)) ? g_type[1:0] : 2'b10;
  assign next_ptr = (grant_idx == PW'(NUM_PORTS-1)) ? '0 : grant_idx + 1'b1;
  assign rid_ok   = ({28'd0, rid} < NUM_PORTS);

  // R beats are steered to the port named by rid; out-of-range ids reach no port
  always_comb begin
    ret_valid = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      ret_valid[i] = rvalid && (rid == 4'(i));
    end
  end

  assign ret_last = ret_valid & {NUM_PORTS{rlast}};
  assign ret_data = rdata;
  assign rready   = 1'b1;
  assign arburst  = 2'b01;
  assign arlock   = 2'b00;
  assign arcache  = 4'b0000;
  assign arprot   = 3'b000;

  // AR register load/hold, per-port busy tracking, round-robin pointer and sticky error flags
  always_ff @(posedge aclk) begin
    if (areset) begin
      arvalid  <= 1'b0;
      arid     <= '0;
      araddr   <= '0;
      arlen    <= '0;
      arsize   <= '0;
      busy     <= '0;
      rr_ptr   <= '0;
      err_resp <= 1'b0;
      err_id   <= 1'b0;
    end else begin
      if (grant_vld) begin
        arvalid <= 1'b1;
        arid    <= 4'(grant_idx);
        araddr  <= g_addr;
        arlen   <= g_line ? 8'(LINE_WORDS-1) : 8'd0;
        arsize  <= {1'b0, g_size};
        rr_ptr  <= next_ptr;
      end else if (arvalid && arready) begin
        arvalid <= 1'b0;
      end
      // Set and clear never target the same port: a busy port cannot be granted
      busy <= (busy | rd_rdy) & ~ret_last;
      if (rvalid && (rresp != 2'b00)) begin
        err_resp <= 1'b1;
      end
      if (rvalid && !rid_ok) begin
        err_id <= 1'b1;
      end
    end
  end

endmodule
